// File: rtl/fetch_sequencer_pkg.sv
// Shared fetch-stage types: sequencer state, queue entry, HLT encoding
// and a saturating add used by the optional statistics counters.
package fetch_sequencer_pkg;

    localparam int DEF_GPR_SIZE  = 64;
    localparam int DEF_INSN_SIZE = 32;

    localparam logic [31:0] INSNBITS_HLT = 32'hD440_0000;

    typedef enum logic [1:0] {
        WARM = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [DEF_INSN_SIZE-1:0] insnbits;
        logic [DEF_GPR_SIZE-1:0]  pc;
    } fetch_entry_t;

    function automatic logic [31:0] sat_add(
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? '1 : s[31:0];
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular fetch FIFO: enq/deq/flush with a zeroed head when empty.
module fetch_queue
    import fetch_sequencer_pkg::*;
#(
    parameter int  QDEPTH  = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enq,
    input  entry_t                  enq_data,
    input  logic                    deq,
    input  logic                    flush,
    output logic                    full,
    output logic [$clog2(QDEPTH):0] count,
    output entry_t                  head_data
);

    localparam int PW = $clog2(QDEPTH);

    entry_t        mem [QDEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW:0]   cnt;
    logic          empty;
    logic          do_enq;
    logic          do_deq;

    assign empty  = (cnt == '0);
    assign full   = (cnt == (PW+1)'(QDEPTH));
    assign do_deq = deq & ~empty & ~flush;
    assign do_enq = enq & (~full | do_deq) & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (do_enq)
                tail <= tail + 1'b1;
            if (do_deq)
                head <= head + 1'b1;
            case ({do_enq, do_deq})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset: the head is masked while empty.
    always_ff @(posedge clk) begin
        if (do_enq)
            mem[tail] <= enq_data;
    end

    assign count     = cnt;
    assign head_data = empty ? '0 : mem[head];

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch PC owner, WARM/RUN/HALT sequencing and fetch queue front end.
// Optional FETCH_STATS_EN adds saturating fetched/flushed/stall counters.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int QDEPTH    = 4,
    parameter int GPR_SIZE  = DEF_GPR_SIZE,
    parameter int INSN_SIZE = DEF_INSN_SIZE
) (
    input  logic                 in_clk,
    input  logic                 in_rst_n,
    input  logic [GPR_SIZE-1:0]  in_entry_pc,
    output logic [GPR_SIZE-1:0]  out_imem_addr,
    input  logic [INSN_SIZE-1:0] in_imem_data,
    input  logic                 in_pd_uncond,
    input  logic [GPR_SIZE-1:0]  in_pd_imm,
    input  logic                 in_rob_mispredict,
    input  logic [GPR_SIZE-1:0]  in_rob_new_pc,
    output logic                 out_d_valid,
    input  logic                 in_d_ready,
    output logic [INSN_SIZE-1:0] out_d_insnbits,
    output logic [GPR_SIZE-1:0]  out_d_pc,
`ifdef FETCH_STATS_EN
    output logic [31:0]          out_stat_fetched,
    output logic [31:0]          out_stat_flushed,
    output logic [31:0]          out_stat_stall,
`endif
    output logic                 out_halted
);

    localparam int CW = $clog2(QDEPTH) + 1;

    typedef struct packed {
        logic [INSN_SIZE-1:0] insnbits;
        logic [GPR_SIZE-1:0]  pc;
    } entry_t;

    fetch_state_t        state;
    fetch_state_t        state_nxt;
    logic [GPR_SIZE-1:0] pc;
    logic [GPR_SIZE-1:0] pc_nxt;

    logic                q_full;
    logic [CW-1:0]       q_count;
    logic                q_empty;
    entry_t              enq_data;
    entry_t              head;

    logic                redirect;
    logic                deq;
    logic                fire;
    logic                enq;
    logic                advance;
    logic                zero_word;
    logic                pc_zero;

    // The ROB is held in reset alongside us during WARM.
    assign redirect  = in_rob_mispredict & (state != WARM);
    assign q_empty   = (q_count == '0);
    assign out_d_valid = ~q_empty & ~in_rob_mispredict;
    assign deq       = out_d_valid & in_d_ready;
    assign zero_word = (in_imem_data == '0);
    assign pc_zero   = (pc == '0);

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state <= WARM;
            pc    <= in_entry_pc;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            WARM: state_nxt = RUN;
            RUN: begin
                if (redirect)
                    state_nxt = RUN;
                else if (fire & (zero_word | pc_zero))
                    state_nxt = HALT;
            end
            HALT: begin
                if (redirect)
                    state_nxt = RUN;
            end
            default: state_nxt = WARM;
        endcase
    end

    always_comb begin
        fire    = (state == RUN) & (~q_full | deq) & ~redirect;
        enq     = fire & ~zero_word;
        advance = enq & ~pc_zero;

        enq_data.insnbits = pc_zero ? INSN_SIZE'(INSNBITS_HLT)
                                    : in_imem_data;
        enq_data.pc       = pc;

        pc_nxt = pc;
        unique case (1'b1)
            redirect:                  pc_nxt = in_rob_new_pc;
            advance & in_pd_uncond:    pc_nxt = pc + in_pd_imm;
            advance & ~in_pd_uncond:   pc_nxt = pc + GPR_SIZE'(4);
            default:                   pc_nxt = pc;
        endcase

        out_halted = (state == HALT) & q_empty;
    end

    fetch_queue #(
        .QDEPTH  (QDEPTH),
        .entry_t (entry_t)
    ) u_queue (
        .clk       (in_clk),
        .rst_n     (in_rst_n),
        .enq       (enq),
        .enq_data  (enq_data),
        .deq       (deq),
        .flush     (redirect),
        .full      (q_full),
        .count     (q_count),
        .head_data (head)
    );

    assign out_imem_addr  = pc;
    assign out_d_insnbits = head.insnbits;
    assign out_d_pc       = head.pc;

`ifdef FETCH_STATS_EN
    logic [31:0] n_fetched;
    logic [31:0] n_flushed;
    logic [31:0] n_stall;

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            n_fetched <= '0;
            n_flushed <= '0;
            n_stall   <= '0;
        end else begin
            if (enq)
                n_fetched <= sat_add(n_fetched, 32'd1);
            if (redirect)
                n_flushed <= sat_add(n_flushed, 32'(q_count));
            if ((state == RUN) & q_full & ~deq)
                n_stall <= sat_add(n_stall, 32'd1);
        end
    end

    assign out_stat_fetched = n_fetched;
    assign out_stat_flushed = n_flushed;
    assign out_stat_stall   = n_stall;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer (FETCH_STATS_EN checks optional).
// Table-driven fetch scenarios plus hand-written stall/redirect/reset cases.
module tb_fetch_sequencer;
    import fetch_sequencer_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b1;
    logic        ready = 1'b0;
    logic        mis = 1'b0;
    logic [63:0] entry = 64'h0;
    logic [63:0] new_pc = 64'h0;
    logic        b_en = 1'b0;
    logic [63:0] b_addr = 64'h0;
    logic [63:0] b_imm = 64'h0;
    logic        z_en = 1'b0;
    logic [63:0] z_addr = 64'h0;

    logic [63:0] imem_addr;
    logic [31:0] imem_data;
    logic        pd_uncond;
    logic        d_valid;
    logic [31:0] d_insn;
    logic [63:0] d_pc;
    logic        halted;
`ifdef FETCH_STATS_EN
    logic [31:0] st_fetched;
    logic [31:0] st_flushed;
    logic [31:0] st_stall;
`endif

    int n_vec = 0;
    int n_bad = 0;

    function automatic logic [31:0] word(input logic [63:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    // imem and predecode models
    assign imem_data = (z_en && imem_addr == z_addr) ? 32'h0 : word(imem_addr);
    assign pd_uncond = b_en && (imem_addr == b_addr);

    fetch_sequencer dut (
        .in_clk            (clk),
        .in_rst_n          (rst_n),
        .in_entry_pc       (entry),
        .out_imem_addr     (imem_addr),
        .in_imem_data      (imem_data),
        .in_pd_uncond      (pd_uncond),
        .in_pd_imm         (b_imm),
        .in_rob_mispredict (mis),
        .in_rob_new_pc     (new_pc),
        .out_d_valid       (d_valid),
        .in_d_ready        (ready),
        .out_d_insnbits    (d_insn),
        .out_d_pc          (d_pc),
`ifdef FETCH_STATS_EN
        .out_stat_fetched  (st_fetched),
        .out_stat_flushed  (st_flushed),
        .out_stat_stall    (st_stall),
`endif
        .out_halted        (halted)
    );

    typedef struct {
        logic [31:0] insn;
        logic [63:0] pc;
    } exp_t;

    exp_t sb[$];
    exp_t me;

    typedef struct {
        logic [63:0] entry;
        logic        b_en;
        logic [63:0] b_addr;
        logic [63:0] b_imm;
        logic        z_en;
        logic [63:0] z_addr;
        int          first;
        int          n;
        logic        halt;
        logic        hlt_last;
        logic [63:0] end_addr;
    } scen_t;

    scen_t       tbl [6];
    logic [63:0] pl [28];

    function automatic scen_t mk(
        input logic [63:0] e, input logic be, input logic [63:0] ba,
        input logic [63:0] bi, input logic ze, input logic [63:0] za,
        input int f, input int n, input logic h, input logic hl,
        input logic [63:0] ea
    );
        scen_t s;
        s.entry = e;  s.b_en = be; s.b_addr = ba; s.b_imm = bi;
        s.z_en = ze;  s.z_addr = za; s.first = f; s.n = n;
        s.halt = h;   s.hlt_last = hl; s.end_addr = ea;
        return s;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", nm, got, exp);
        end
    endtask

    function automatic void push(input logic [63:0] p, input logic hlt);
        exp_t e;
        e.pc   = p;
        e.insn = hlt ? INSNBITS_HLT : word(p);
        sb.push_back(e);
    endfunction

    // Scoreboard: compare every accepted head against the expected order.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && d_valid === 1'b1 && ready === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_deq: got pc %h, want no dequeue", d_pc);
            end else begin
                me = sb.pop_front();
                chk("deq_pc", d_pc, me.pc);
                chk("deq_insn", 64'(d_insn), 64'(me.insn));
            end
        end
    end

    task automatic do_reset(input logic [63:0] e, input logic r);
        @(posedge clk); #1;
        entry = e;
        ready = r;
        mis   = 1'b0;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("rst_valid", 64'(d_valid), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_addr", imem_addr, e);
`ifdef FETCH_STATS_EN
        chk("rst_stat_fetched", 64'(st_fetched), 64'd0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (sb.size() != 0 && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        chk("drain_left", 64'(sb.size()), 64'd0);
        @(posedge clk); #1;
        ready = 1'b0;
        sb.delete();
    endtask

    initial begin
        pl = '{64'h1000, 64'h1004, 64'h1008, 64'h100c, 64'h1010,
               64'h1000, 64'h1004, 64'h1008, 64'h1000, 64'h1004,
               64'h1008, 64'h1000,
               64'h1000, 64'h1004, 64'h1008, 64'h1028, 64'h102c,
               64'h1000, 64'h1004, 64'h1008, 64'h0,
               64'h1000, 64'h1004, 64'h1008, 64'h100c,
               64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0};

        tbl[0] = mk(64'h1000, 0, 64'h0, 64'h0, 0, 64'h0, 0, 5, 0, 0, 64'h0);
        tbl[1] = mk(64'h1000, 1, 64'h1008, -64'sd8, 0, 64'h0, 5, 7, 0, 0, 64'h0);
        tbl[2] = mk(64'h1000, 1, 64'h1008, 64'h20, 0, 64'h0, 12, 5, 0, 0, 64'h0);
        tbl[3] = mk(64'h1000, 1, 64'h1008, -64'sh1008, 0, 64'h0, 17, 4, 1, 1, 64'h0);
        tbl[4] = mk(64'h1000, 0, 64'h0, 64'h0, 1, 64'h1010, 21, 4, 1, 0, 64'h1010);
        tbl[5] = mk(64'hFFFF_FFFF_FFFF_FFF8, 0, 64'h0, 64'h0, 0, 64'h0,
                    25, 3, 1, 1, 64'h0);

        for (int s = 0; s < 6; s++) begin
            b_en   = tbl[s].b_en;
            b_addr = tbl[s].b_addr;
            b_imm  = tbl[s].b_imm;
            z_en   = tbl[s].z_en;
            z_addr = tbl[s].z_addr;
            do_reset(tbl[s].entry, 1'b1);
            for (int i = 0; i < tbl[s].n; i++)
                push(pl[tbl[s].first + i],
                     tbl[s].hlt_last && (i == tbl[s].n - 1));
            @(negedge clk);
            chk("warm_valid", 64'(d_valid), 64'd0);
            @(negedge clk);
            chk("first_fetch_valid", 64'(d_valid), 64'd0);
            drain(40);
            @(negedge clk);
            chk("scen_halted", 64'(halted), 64'(tbl[s].halt));
            if (tbl[s].halt)
                chk("halt_addr", imem_addr, tbl[s].end_addr);
        end

        // Redirect out of HALT (left at pc 0 by the last scenario).
        @(posedge clk); #1;
        mis = 1'b1;
        new_pc = 64'h1000;
        ready = 1'b1;
        push(64'h1000, 0);
        push(64'h1004, 0);
        push(64'h1008, 0);
        #1;
        chk("halt_mis_valid", 64'(d_valid), 64'd0);
        chk("halt_mis_halted", 64'(halted), 64'd1);
        @(posedge clk); #1;
        mis = 1'b0;
        @(negedge clk);
        chk("resume_halted", 64'(halted), 64'd0);
        drain(20);

        // Decode stalled: queue fills to 4 and the PC holds.
        b_en = 1'b0;
        z_en = 1'b0;
        do_reset(64'h1000, 1'b0);
        repeat (8) @(negedge clk);
        chk("stall_addr", imem_addr, 64'h1010);
        chk("stall_valid", 64'(d_valid), 64'd1);
        chk("stall_head", d_pc, 64'h1000);
`ifdef FETCH_STATS_EN
        chk("stat_fetched", 64'(st_fetched), 64'd4);
        chk("stat_stall_nz", 64'(st_stall != 0), 64'd1);
`endif
        @(negedge clk);
        chk("stall_hold", imem_addr, 64'h1010);
        for (int i = 0; i < 6; i++)
            push(64'h1000 + 64'(4 * i), 0);
        @(posedge clk); #1;
        ready = 1'b1;
        drain(30);

        // Mispredict with three queued entries.
        do_reset(64'h1000, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("pre_mis_valid", 64'(d_valid), 64'd1);
        chk("pre_mis_head", d_pc, 64'h1000);
        mis = 1'b1;
        new_pc = 64'h2000;
        #1;
        chk("mis_valid", 64'(d_valid), 64'd0);
        @(posedge clk); #1;
        mis = 1'b0;
        ready = 1'b1;
        push(64'h2000, 0);
        push(64'h2004, 0);
        push(64'h2008, 0);
`ifdef FETCH_STATS_EN
        chk("stat_flushed", 64'(st_flushed), 64'd3);
`endif
        @(negedge clk);
        chk("post_mis_valid", 64'(d_valid), 64'd0);
        drain(20);

        // Asynchronous reset while the queue holds entries.
        entry = 64'h3000;
        repeat (3) @(negedge clk);
        #2;
        chk("pre_rst_valid", 64'(d_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async_valid", 64'(d_valid), 64'd0);
        chk("async_halted", 64'(halted), 64'd0);
        chk("async_addr", imem_addr, 64'h3000);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        ready = 1'b1;
        push(64'h3000, 0);
        push(64'h3004, 0);
        drain(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Owns the architectural fetch PC and drives the combinational instruction memory address each cycle.
- Buffers fetched {insnbits, pc} pairs in a small FIFO and hands them to decode over a valid/ready handshake.
- Applies ROB mispredict redirects (with queue flush), static redirects for unconditional branches, and halt detection.
- Sits between imem/predecode and decode; a fetch stage wraps it.

Parameters:
- QDEPTH, 4, fetch queue entries; power of two, ≥2.
- GPR_SIZE, 64, PC width.
- INSN_SIZE, 32, instruction word width.

Ports:
- in_clk  input  1  clock, rising edge.
- in_rst_n  input  1  asynchronous, active-low reset.
- in_entry_pc  input  GPR_SIZE  program entry point; sampled while in reset.
- out_imem_addr  output  GPR_SIZE  current PC to imem.
- in_imem_data  input  INSN_SIZE  imem word at out_imem_addr, same cycle.
- in_pd_uncond  input  1  predecode: word is B or BL.
- in_pd_imm  input  GPR_SIZE  predecode: signed byte offset of the B/BL target.
- in_rob_mispredict  input  1  redirect request.
- in_rob_new_pc  input  GPR_SIZE  redirect target.
- out_d_valid  output  1  queue head valid.
- in_d_ready  input  1  decode accepts head.
- out_d_insnbits  output  INSN_SIZE  head instruction.
- out_d_pc  output  GPR_SIZE  head PC.
- out_halted  output  1  state HALT and queue empty.

Behaviour:
- Reset (in_rst_n=0, asynchronous):
  - PC <= in_entry_pc; state WARM; head, tail and count <= 0.
  - out_d_valid=0, out_halted=0.
- States:
  - WARM: exactly one cycle after reset release; no fetch, no enqueue. Goes to RUN.
  - RUN: normal fetch.
  - HALT: no fetch and PC held; the queue still drains.
- Fetch fires in RUN when (count<QDEPTH or deq) and no mispredict is active.
  - deq = out_d_valid & in_d_ready.
  - A word is fetched at most once per cycle.
- Fetch outcome, first match wins:
  1. in_imem_data==0: no enqueue; PC held; go HALT.
  2. PC==0 (return from main): enqueue {INSNBITS_HLT, 0}; go HALT.
  3. in_pd_uncond=1: enqueue {data, PC}; PC <= PC + in_pd_imm, signed, modulo 2^GPR_SIZE.
  4. Otherwise: enqueue {data, PC}; PC <= PC+4, modulo 2^GPR_SIZE.
- When fetch does not fire (queue full with no deq), PC is held. The same word is re-presented next cycle.
- Dequeue:
  - out_d_valid = (count!=0) & ~in_rob_mispredict.
  - Head outputs come directly from the queue storage at head; they are 0 when count==0.
  - Simultaneous enqueue and dequeue leaves count unchanged, including when full.
  - Pointers are $clog2(QDEPTH) bits and wrap naturally.
- Mispredict (in_rob_mispredict=1) has the highest priority, in any state except WARM:
  - Same cycle: queue flushed (count, head, tail <= 0); no enqueue; out_d_valid forced 0.
  - PC <= in_rob_new_pc; state <= RUN, including from HALT.
- Mispredict during WARM is ignored; the ROB is also in reset.
- Fetch latency: imem word at PC in cycle N is visible at out_d_* in cycle N+1 at the earliest.
- out_halted = (state==HALT) & (count==0), registered-state combinational.
- Reset mid-operation discards all queue contents and state immediately.

Optional Feature:
- Macro FETCH_STATS_EN.
- Defined: adds three saturating 32-bit counters, cleared on reset, with output ports out_stat_fetched, out_stat_flushed and out_stat_stall.
  - out_stat_fetched: enqueues.
  - out_stat_flushed: entries discarded by mispredict flushes.
  - out_stat_stall: RUN cycles with the queue full and no deq.
- Undefined: counters and ports absent; behaviour otherwise identical.

Decomposition:
- Shared package (data_structures.sv):
  - fetch_state_t enum {WARM, RUN, HALT}.
  - fetch_entry_t struct {insnbits, pc}.
  - INSNBITS_HLT constant, already shared.
- Sub-module fetch_queue: parameterized circular FIFO with enq, deq, flush, full/empty and head data.
- fetch_sequencer keeps the PC, state machine and fetch-outcome logic.

Test Plan:
- Reset with in_entry_pc=0x1000 and imem words non-zero, in_d_ready=1: WARM for 1 cycle; then out_d_pc=0x1000, 0x1004, 0x1008 on consecutive cycles.
- in_d_ready=0 with QDEPTH=4: exactly 4 enqueues, PC stalls at entry+16, count stays 4. Raising ready drains in order with no lost or duplicated PCs.
- B at 0x1008 with in_pd_imm=-8: the next entry has pc=0x1000. Repeat with imm=+0x20: next pc=0x1028.
- Queue holding 3 entries, mispredict with new_pc=0x2000: out_d_valid=0 that cycle; the next head pc is 0x2000. With FETCH_STATS_EN defined, flushed increments by 3.
- PC reaches 0: HLT enqueued at pc 0, state HALT, out_halted=1 after drain. A zero word at 0x1010 instead: no enqueue, HALT.
- Mispredict while HALT to 0x1000: resumes RUN and out_halted drops. Assert in_rst_n low mid-stream: out_d_valid=0 immediately, without waiting for a clock edge.
